// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: word/state types, quarterround rotates, the
// column/diagonal index tables, the sigma constants and the engine FSM encoding.
package chacha_pkg;

  localparam int ROT_A = 16;
  localparam int ROT_B = 12;
  localparam int ROT_C = 8;
  localparam int ROT_D = 7;

  // Word i occupies bits [32*i+31:32*i] of the flat 512-bit bus.
  typedef logic [15:0][31:0] chacha_state_t;

  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e,
                                        32'h79622d32, 32'h6b206574};

  // Quarterround groups (a, b, c, d) for each half-round.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } chacha_fsm_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr_comb.sv
// Purely combinational ChaCha quarterround on four 32-bit words.
module chacha_qr_comb
  import chacha_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_a1, w_b1, w_c1, w_d1;
  logic [31:0] w_a2, w_b2, w_c2, w_d2;

  assign w_a1 = i_a + i_b;
  assign w_d1 = rotl32(i_d ^ w_a1, ROT_A);
  assign w_c1 = i_c + w_d1;
  assign w_b1 = rotl32(i_b ^ w_c1, ROT_B);
  assign w_a2 = w_a1 + w_b1;
  assign w_d2 = rotl32(w_d1 ^ w_a2, ROT_C);
  assign w_c2 = w_c1 + w_d2;
  assign w_b2 = rotl32(w_b1 ^ w_c2, ROT_D);

  assign o_a = w_a2;
  assign o_b = w_b2;
  assign o_c = w_c2;
  assign o_d = w_d2;

endmodule

// File: rtl/chacha_block_iter.sv
// Iterative ChaCha block engine: QR_PER_CYCLE quarterrounds per clock over
// ROUNDS half-rounds, then the feed-forward add into a held output block.
//
// state    | meaning
// ST_IDLE  | ready for a new input state
// ST_ROUND | applying quarterround groups of the current half-round
// ST_FINAL | feed-forward add of working + saved input
// ST_DONE  | keystream block valid, waiting for out_ready
module chacha_block_iter
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  chacha_state_t in_state,
  output logic          out_valid,
  input  logic          out_ready,
  output chacha_state_t out_block,
  output logic          busy
);

  localparam int STEPS = 4 / QR_PER_CYCLE;
  localparam int HW    = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
    $error("chacha_block_iter: ROUNDS must be even and >= 2");
  end
  if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qr
    $error("chacha_block_iter: QR_PER_CYCLE must be 1, 2 or 4");
  end

  chacha_fsm_t   r_state, w_state_next;
  chacha_state_t r_work, r_saved, r_out;
  chacha_state_t w_work_next;
  logic [1:0]    r_sub;
  logic [HW-1:0] r_half;
  logic          r_diag;
  logic          w_sub_wrap, w_last;

  logic [3:0]  w_idx  [QR_PER_CYCLE][4];
  logic [31:0] w_qin  [QR_PER_CYCLE][4];
  logic [31:0] w_qout [QR_PER_CYCLE][4];

  assign w_sub_wrap = (r_sub == 2'(STEPS - 1));
  assign w_last     = w_sub_wrap && (r_half == HW'(ROUNDS - 1));

  // Groups inside a half-round are disjoint, so lanes never collide.
  for (genvar k = 0; k < QR_PER_CYCLE; k++) begin : g_qr
    logic [1:0] w_grp;
    assign w_grp = 2'(int'(r_sub) * QR_PER_CYCLE + k);
    for (genvar p = 0; p < 4; p++) begin : g_pos
      assign w_idx[k][p] = r_diag ? DIAG_IDX[w_grp][p] : COL_IDX[w_grp][p];
      assign w_qin[k][p] = r_work[w_idx[k][p]];
    end
    chacha_qr_comb u_qr (
      .i_a (w_qin[k][0]),
      .i_b (w_qin[k][1]),
      .i_c (w_qin[k][2]),
      .i_d (w_qin[k][3]),
      .o_a (w_qout[k][0]),
      .o_b (w_qout[k][1]),
      .o_c (w_qout[k][2]),
      .o_d (w_qout[k][3])
    );
  end

  always_comb begin
    w_work_next = r_work;
    for (int k = 0; k < QR_PER_CYCLE; k++) begin
      for (int p = 0; p < 4; p++) begin
        w_work_next[w_idx[k][p]] = w_qout[k][p];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = ST_ROUND;
      end
      ST_ROUND: if (w_last) w_state_next = ST_FINAL;
      ST_FINAL: w_state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_saved <= '0;
      r_out   <= '0;
      r_sub   <= '0;
      r_half  <= '0;
      r_diag  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= in_state;
            r_saved <= in_state;
            r_sub   <= '0;
            r_half  <= '0;
            r_diag  <= 1'b0;
          end
        end
        ST_ROUND: begin
          r_work <= w_work_next;
          if (w_sub_wrap) begin
            r_sub  <= '0;
            r_diag <= ~r_diag;
            r_half <= r_half + 1'b1;
          end else begin
            r_sub <= r_sub + 2'd1;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 16; i++) r_out[i] <= r_work[i] + r_saved[i];
        end
        default: ;
      endcase
    end
  end

  assign out_block = r_out;

endmodule

// File: doc/chacha_block_iter.md
Name: chacha_block_iter

Overview:
- Iterative ChaCha block-function engine, parametrised in round count and quarterround parallelism.
- Accepts a 16-word input state over a valid/ready handshake.
- Runs ROUNDS rounds, alternating column and diagonal rounds, then performs the feed-forward add and presents the 512-bit keystream block.
- Sits between key/nonce/counter state assembly and the stream XOR datapath. Reuses a combinational quarterround.

Parameters:
- ROUNDS, 20, total rounds (8/12/20 legal; must be even, >=2).
- QR_PER_CYCLE, 4, quarterrounds evaluated per clock (1, 2 or 4).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept a state
- in_state  in  512  input words; word i = bits [32*i+31:32*i]
- out_valid  out  1  keystream block valid
- out_ready  in  1  consumer accepts block
- out_block  out  512  feed-forward result, same word packing
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready=1; out_valid=0; busy=0; out_block=0; working regs, saved input and counters=0.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, capture in_state into both the working regs and the saved-input regs, clear step counters, go to ROUND.
- ROUND: each cycle apply QR_PER_CYCLE quarterrounds of the current half-round.
  - Column half: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
  - Diagonal half: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - Groups within a half are applied in listed order, QR_PER_CYCLE at a time. They are disjoint, so parallel application is exact.
  - The sub-step counter wraps at 4/QR_PER_CYCLE; on wrap, toggle column/diagonal.
  - The round counter counts half-rounds 0..ROUNDS-1. After the last step go to FINAL.
- FINAL: one cycle; out_block[i] = working[i] + saved[i] mod 2^32 per word. Go to DONE.
- DONE: out_valid=1, out_block stable. On out_ready go to IDLE; out_valid deasserts next cycle.
- in_ready=0 in ROUND/FINAL/DONE. in_valid there is ignored and in_state is not sampled.
- Latency, accept edge to out_valid high: ROUNDS*4/QR_PER_CYCLE + 1 cycles.
  - Defaults: 21 cycles.
  - QR_PER_CYCLE=1, ROUNDS=8: 33 cycles.
- Throughput: minimum 1 idle cycle between out handshake and next accept.
- Quarterround (32-bit, mod 2^32 adds, left rotates):
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Backpressure: DONE holds indefinitely with out_block unchanged while out_ready=0.
- Reset mid-operation (any state): immediate return to reset values; no partial block is ever emitted.
- out_ready while not in DONE: ignored.
- Illegal parameters (odd ROUNDS, QR_PER_CYCLE not in {1,2,4}): elaboration-time error.

Decomposition:
- Shared package chacha_pkg:
  - rotate constants 16/12/8/7
  - column and diagonal index tables as constant arrays
  - sigma constants 61707865 3320646e 79622d32 6b206574
  - state typedef (16 x 32-bit word array)
  - FSM state enum
- Sub-module chacha_qr_comb: purely combinational quarterround (a,b,c,d -> a',b',c',d'), instantiated QR_PER_CYCLE times with index muxing from the counters.

Test Plan:
- Quarterround unit: chacha_qr_comb with a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> a'=ea2a92f4 b'=cb1cf8ce c'=4581472e d'=5881c4bb.
- Block vector, defaults: sigma, key 00010203..1c1d1e1f, counter 1, nonce 09000000 4a000000 00000000 (LE words) -> out_block words e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2; out_valid exactly 21 cycles after accept.
- Parallelism sweep: the same vector with QR_PER_CYCLE=1 and 2 -> identical out_block; latency 81 and 41 cycles.
- Backpressure: hold out_ready=0 for 50 cycles -> out_valid stays 1, out_block constant, in_ready=0; pulse out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-ROUND: assert reset at cycle 7 after accept -> out_valid=0, in_ready=1, busy=0 immediately; re-issue the vector -> correct block.
- Ignored input: toggle in_valid with garbage in_state during ROUND -> output still equals the first vector.
